// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the fetch (imem), data (dmem) and downstream
// memory (mem) signal groups seen by mem_port_arbiter.
// master = arbiter view, slave = environment view (pipeline + memory model).
interface mem_port_arbiter_if;
  // fetch requester
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  // data requester
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  // unified downstream port
  logic [31:0] mem_addr;
  logic [3:0]  mem_rmask;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        mem_resp;
  logic [31:0] mem_rdata;

  modport master (
    input  imem_addr, imem_rmask,
    output imem_rdata, imem_resp,
    input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    output dmem_rdata, dmem_resp,
    output mem_addr, mem_rmask, mem_wmask, mem_wdata,
    input  mem_resp, mem_rdata
  );

  modport slave (
    output imem_addr, imem_rmask,
    input  imem_rdata, imem_resp,
    output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    input  dmem_rdata, dmem_resp,
    input  mem_addr, mem_rmask, mem_wmask, mem_wdata,
    output mem_resp, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (imem)
// and data access (dmem). One pending slot per side, one outstanding
// downstream transaction, zero-latency response routing to the owner.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (round-robin tie breaking;
// when undefined dmem has fixed priority over imem).
module mem_port_arbiter (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // pending slots
  logic        ipend_valid_reg, ipend_valid_next;
  logic [31:0] ipend_addr_reg,  ipend_addr_next;
  logic [3:0]  ipend_rmask_reg, ipend_rmask_next;

  logic        dpend_valid_reg, dpend_valid_next;
  logic [31:0] dpend_addr_reg,  dpend_addr_next;
  logic [3:0]  dpend_rmask_reg, dpend_rmask_next;
  logic [3:0]  dpend_wmask_reg, dpend_wmask_next;
  logic [31:0] dpend_wdata_reg, dpend_wdata_next;

  // downstream output registers
  logic [31:0] mem_addr_reg,  mem_addr_next;
  logic [3:0]  mem_rmask_reg, mem_rmask_next;
  logic [3:0]  mem_wmask_reg, mem_wmask_next;
  logic [31:0] mem_wdata_reg, mem_wdata_next;

  logic        i_req, d_req;
  logic        i_drop, d_drop;
  logic        i_acc, d_acc;
  logic        i_elig, d_elig;
  logic        grant_point;
  logic        grant_i, grant_d;
  logic        i_own, d_own;

  // candidate request per side: the slot if occupied, else this cycle's pulse
  logic [31:0] i_sel_addr;
  logic [3:0]  i_sel_rmask;
  logic [31:0] d_sel_addr;
  logic [3:0]  d_sel_rmask;
  logic [3:0]  d_sel_wmask;
  logic [31:0] d_sel_wdata;

  assign i_req = (bus.imem_rmask != 4'd0);
  assign d_req = ((bus.dmem_rmask | bus.dmem_wmask) != 4'd0);

  // A side can hold one transaction on the port plus one in its slot; a
  // further pulse while the slot is occupied has nowhere to go and is dropped.
  assign i_drop = i_req && ipend_valid_reg;
  assign d_drop = d_req && dpend_valid_reg;
  assign i_acc  = i_req && !ipend_valid_reg;
  assign d_acc  = d_req && !dpend_valid_reg;

  assign i_elig = ipend_valid_reg || i_acc;
  assign d_elig = dpend_valid_reg || d_acc;

  // the port is free to take a new transaction when idle or on the completing cycle
  assign grant_point = (state_reg == IDLE) || bus.mem_resp;

  assign i_sel_addr  = ipend_valid_reg ? ipend_addr_reg  : bus.imem_addr;
  assign i_sel_rmask = ipend_valid_reg ? ipend_rmask_reg : bus.imem_rmask;
  assign d_sel_addr  = dpend_valid_reg ? dpend_addr_reg  : bus.dmem_addr;
  assign d_sel_rmask = dpend_valid_reg ? dpend_rmask_reg : bus.dmem_rmask;
  assign d_sel_wmask = dpend_valid_reg ? dpend_wmask_reg : bus.dmem_wmask;
  assign d_sel_wdata = dpend_valid_reg ? dpend_wdata_reg : bus.dmem_wdata;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // 1 = dmem was granted last; reset value DMEM so imem wins the first tie
  logic last_d_reg, last_d_next;
  assign grant_d = d_elig && (!i_elig || !last_d_reg);
`else
  assign grant_d = d_elig;
`endif
  assign grant_i = i_elig && !grant_d;

  // next-state, slot and downstream-register logic
  always_comb begin
    state_next       = state_reg;
    ipend_valid_next = ipend_valid_reg;
    ipend_addr_next  = ipend_addr_reg;
    ipend_rmask_next = ipend_rmask_reg;
    dpend_valid_next = dpend_valid_reg;
    dpend_addr_next  = dpend_addr_reg;
    dpend_rmask_next = dpend_rmask_reg;
    dpend_wmask_next = dpend_wmask_reg;
    dpend_wdata_next = dpend_wdata_reg;
    mem_addr_next    = mem_addr_reg;
    mem_rmask_next   = mem_rmask_reg;
    mem_wmask_next   = mem_wmask_reg;
    mem_wdata_next   = mem_wdata_reg;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_d_next      = last_d_reg;
`endif

    // park accepted pulses; a grant below may consume them on the same edge
    if (i_acc) begin
      ipend_valid_next = 1'b1;
      ipend_addr_next  = bus.imem_addr;
      ipend_rmask_next = bus.imem_rmask;
    end
    if (d_acc) begin
      dpend_valid_next = 1'b1;
      dpend_addr_next  = bus.dmem_addr;
      dpend_rmask_next = bus.dmem_rmask;
      dpend_wmask_next = bus.dmem_wmask;
      dpend_wdata_next = bus.dmem_wdata;
    end

    if (grant_point) begin
      if (grant_d) begin
        state_next       = D_BUSY;
        dpend_valid_next = 1'b0;
        mem_addr_next    = d_sel_addr & 32'hFFFF_FFFC;
        mem_wmask_next   = d_sel_wmask;
        // a request carrying both masks is a store; the read side is suppressed
        mem_rmask_next   = (d_sel_wmask != 4'd0) ? 4'd0 : d_sel_rmask;
        mem_wdata_next   = (d_sel_wmask != 4'd0) ? d_sel_wdata : 32'd0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_d_next      = 1'b1;
`endif
      end else if (grant_i) begin
        state_next       = I_BUSY;
        ipend_valid_next = 1'b0;
        mem_addr_next    = i_sel_addr & 32'hFFFF_FFFC;
        mem_rmask_next   = i_sel_rmask;
        mem_wmask_next   = 4'd0;
        mem_wdata_next   = 32'd0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_d_next      = 1'b0;
`endif
      end else begin
        state_next     = IDLE;
        mem_addr_next  = 32'd0;
        mem_rmask_next = 4'd0;
        mem_wmask_next = 4'd0;
        mem_wdata_next = 32'd0;
      end
    end
  end

  // state, slot and output registers; reset abandons anything in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      ipend_valid_reg <= 1'b0;
      ipend_addr_reg  <= 32'd0;
      ipend_rmask_reg <= 4'd0;
      dpend_valid_reg <= 1'b0;
      dpend_addr_reg  <= 32'd0;
      dpend_rmask_reg <= 4'd0;
      dpend_wmask_reg <= 4'd0;
      dpend_wdata_reg <= 32'd0;
      mem_addr_reg    <= 32'd0;
      mem_rmask_reg   <= 4'd0;
      mem_wmask_reg   <= 4'd0;
      mem_wdata_reg   <= 32'd0;
    end else begin
      state_reg       <= state_next;
      ipend_valid_reg <= ipend_valid_next;
      ipend_addr_reg  <= ipend_addr_next;
      ipend_rmask_reg <= ipend_rmask_next;
      dpend_valid_reg <= dpend_valid_next;
      dpend_addr_reg  <= dpend_addr_next;
      dpend_rmask_reg <= dpend_rmask_next;
      dpend_wmask_reg <= dpend_wmask_next;
      dpend_wdata_reg <= dpend_wdata_next;
      mem_addr_reg    <= mem_addr_next;
      mem_rmask_reg   <= mem_rmask_next;
      mem_wmask_reg   <= mem_wmask_next;
      mem_wdata_reg   <= mem_wdata_next;
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // round-robin pointer register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_d_reg <= 1'b1;
    end else begin
      last_d_reg <= last_d_next;
    end
  end
`endif

  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_rmask = mem_rmask_reg;
  assign bus.mem_wmask = mem_wmask_reg;
  assign bus.mem_wdata = mem_wdata_reg;

  // responses are routed combinationally to whichever side owns the port;
  // a completion seen while idle (e.g. after a reset) is not forwarded
  assign i_own = (state_reg == I_BUSY);
  assign d_own = (state_reg == D_BUSY);
  assign bus.imem_resp = i_own && bus.mem_resp;
  assign bus.dmem_resp = d_own && bus.mem_resp;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign bus.imem_rdata[8*gi +: 8] = i_own ? bus.mem_rdata[8*gi +: 8] : 8'h00;
    assign bus.dmem_rdata[8*gi +: 8] = d_own ? bus.mem_rdata[8*gi +: 8] : 8'h00;
  end

`ifndef SYNTHESIS
  // flag protocol violations: a pulse arriving while its side's slot is full
  always_ff @(posedge clk) begin
    assert (!i_drop) else $warning("mem_port_arbiter: imem request dropped, pending slot occupied");
    assert (!d_drop) else $warning("mem_port_arbiter: dmem request dropped, pending slot occupied");
  end
`endif

endmodule
